// File: rtl/cpu_output_capture_pkg.sv
// Shared widths and entry layout for the CPU output capture block.
// An entry is the cycle stamp in the upper bits and the captured bus value in the lower bits.
package capture_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int STAMP_W_DEF = 16;
   localparam int DEPTH_DEF   = 16;
   localparam int ENTRY_W     = DATA_W_DEF + STAMP_W_DEF;

   typedef struct packed {
      logic [STAMP_W_DEF-1:0] stamp;
      logic [DATA_W_DEF-1:0]  data;
   } entry_t;

   function automatic int entry_width(input int data_w, input int stamp_w);
      return data_w + stamp_w;
   endfunction

endpackage

// File: rtl/cpu_output_capture_if.sv
// Control, observed-bus and drain-port signals of the capture block.
// The master side is whoever drives the capture block: a host or a bench.
interface cpu_output_capture_if
   import capture_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int STAMP_W = STAMP_W_DEF,
   parameter int DEPTH   = DEPTH_DEF
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               enable;
   logic               clear;
   logic [DATA_W-1:0]  cpu_output;
   logic               rd_ready;
   logic               rd_valid;
   logic [DATA_W-1:0]  rd_data;
   logic [STAMP_W-1:0] rd_stamp;
   logic [CNT_W-1:0]   count;
   logic               overflow;

   modport master (
      output enable, clear, cpu_output, rd_ready,
      input  rd_valid, rd_data, rd_stamp, count, overflow
   );

   modport slave (
      input  enable, clear, cpu_output, rd_ready,
      output rd_valid, rd_data, rd_stamp, count, overflow
   );

endinterface

// File: rtl/cpu_output_capture_fifo.sv
// First-word fall-through synchronous FIFO.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module sync_fifo_fwft #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot, so a full FIFO can still accept the push.
   assign do_push = push && (!full || do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/cpu_output_capture.sv
// Watches the CPU output bus and queues every new value with the cycle stamp it appeared on.
// Holds the stamp counter, change detect, first-sample flag and sticky overflow.
module cpu_output_capture
   import capture_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int STAMP_W = STAMP_W_DEF,
   parameter int DEPTH   = DEPTH_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   cpu_output_capture_if.slave bus
);

   typedef struct packed {
      logic [STAMP_W-1:0] stamp;
      logic [DATA_W-1:0]  data;
   } cap_entry_t;

   logic [STAMP_W-1:0] stamp;
   logic [DATA_W-1:0]  prev;
   logic               first;
   logic               capture;
   logic               ovf;
   logic               full;
   logic               empty;
   cap_entry_t         wr_entry;
   cap_entry_t         rd_entry;

   assign capture        = bus.enable && (first || (bus.cpu_output != prev));
   assign wr_entry.stamp = stamp;
   assign wr_entry.data  = bus.cpu_output;

   // First is re-armed whenever capture is paused, so resuming always records a sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stamp <= '0;
         prev  <= '0;
         first <= 1'b1;
      end else if (bus.enable) begin
         stamp <= stamp + 1'b1;
         if (capture) begin
            prev  <= bus.cpu_output;
            first <= 1'b0;
         end
      end else begin
         first <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (bus.clear) begin
         ovf <= 1'b0;
      end else if (capture && full && !bus.rd_ready) begin
         ovf <= 1'b1;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (DATA_W + STAMP_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (capture),
      .pop     (bus.rd_ready),
      .clear   (bus.clear),
      .wr_data (wr_entry),
      .rd_data (rd_entry),
      .full    (full),
      .empty   (empty),
      .count   (bus.count)
   );

   assign bus.rd_valid = !empty;
   assign bus.rd_data  = rd_entry.data;
   assign bus.rd_stamp = rd_entry.stamp;
   assign bus.overflow = ovf;

endmodule

// File: tb/tb_cpu_output_capture.sv
// Directed and randomized checks of cpu_output_capture against a queue-based capture log.
module tb_cpu_output_capture;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   cpu_output_capture_if #(.DATA_W(16), .STAMP_W(16), .DEPTH(DEPTH)) bus ();

   cpu_output_capture #(.DATA_W(16), .STAMP_W(16), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference log: each element is {stamp, data} of a capture still waiting to be read.
   logic [15:0] m_stamp;
   logic [15:0] m_prev;
   logic        m_first;
   logic        m_ovf;
   logic [31:0] m_q [$];

   task automatic modelReset();
      m_stamp = 16'd0;
      m_prev  = 16'd0;
      m_first = 1'b1;
      m_ovf   = 1'b0;
      m_q.delete();
   endtask

   task automatic modelEdge();
      logic popped;
      logic cap;
      popped = (m_q.size() != 0) && bus.rd_ready;
      cap    = bus.enable && (m_first || (bus.cpu_output != m_prev));
      if (bus.clear) begin
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         if (popped) void'(m_q.pop_front());
         if (cap) begin
            if (m_q.size() < DEPTH) m_q.push_back({m_stamp, bus.cpu_output});
            else m_ovf = 1'b1;
         end
      end
      if (bus.enable) begin
         if (cap) begin
            m_prev  = bus.cpu_output;
            m_first = 1'b0;
         end
         m_stamp = m_stamp + 16'd1;
      end else begin
         m_first = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check("rd_valid", 32'(bus.rd_valid), 32'(m_q.size() != 0));
      check("count", 32'(bus.count), 32'(m_q.size()));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      if (m_q.size() != 0) begin
         check("rd_stamp", 32'(bus.rd_stamp), 32'(m_q[0][31:16]));
         check("rd_data", 32'(bus.rd_data), 32'(m_q[0][15:0]));
      end
   endtask

   task automatic applyStimulus(input logic en, input logic clr, input logic [15:0] data,
                                input logic rdy);
      bus.enable     = en;
      bus.clear      = clr;
      bus.cpu_output = data;
      bus.rd_ready   = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) modelEdge();
      else modelReset();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] d;
      int guard;
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      modelReset();
      #12;
      check("reset_valid", 32'(bus.rd_valid), 32'd0);
      check("reset_count", 32'(bus.count), 32'd0);
      check("reset_ovf", 32'(bus.overflow), 32'd0);
      check("reset_data", 32'(bus.rd_data), 32'd0);
      check("reset_stamp", 32'(bus.rd_stamp), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Constant input after reset: a single first-sample entry.
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      tick();
      check("first_count", 32'(bus.count), 32'd1);
      check("first_stamp", 32'(bus.rd_stamp), 32'd0);
      check("first_data", 32'(bus.rd_data), 32'd0);
      repeat (20) tick();
      check("const_hold", 32'(bus.count), 32'd1);

      // Changes at stamps 3 and 7 with the consumer always ready.
      doReset();
      for (int s = 0; s < 10; s++) begin
         d = (s >= 7) ? 16'h00A0 : (s >= 3) ? 16'h0005 : 16'h0000;
         applyStimulus(1'b1, 1'b0, d, 1'b1);
         tick();
         if (s == 3 || s == 7) begin
            check("chg_valid", 32'(bus.rd_valid), 32'd1);
            check("chg_stamp", 32'(bus.rd_stamp), 32'(s));
            check("chg_data", 32'(bus.rd_data), (s == 3) ? 32'h5 : 32'hA0);
         end
         if (s == 4 || s == 8) check("chg_pulse", 32'(bus.rd_valid), 32'd0);
      end

      // Seventeen distinct values into a stalled FIFO.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
         tick();
      end
      check("ovf_count", 32'(bus.count), 32'd16);
      check("ovf_flag", 32'(bus.overflow), 32'd1);
      check("ovf_head", 32'(bus.rd_data), 32'h0100);
      applyStimulus(1'b1, 1'b0, 16'h0110, 1'b1);
      repeat (16) tick();
      check("ovf_drained", 32'(bus.count), 32'd0);
      check("ovf_sticky", 32'(bus.overflow), 32'd1);
      applyStimulus(1'b1, 1'b1, 16'h0110, 1'b0);
      tick();
      check("clr_count", 32'(bus.count), 32'd0);
      check("clr_ovf", 32'(bus.overflow), 32'd0);

      // Full FIFO with a pop and a push on the same edge.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b0);
         tick();
      end
      check("full_count", 32'(bus.count), 32'd16);
      applyStimulus(1'b1, 1'b0, 16'h0300, 1'b1);
      tick();
      check("fullpop_count", 32'(bus.count), 32'd16);
      check("fullpop_ovf", 32'(bus.overflow), 32'd0);
      check("fullpop_head", 32'(bus.rd_data), 32'h0201);
      repeat (15) tick();
      check("tail_data", 32'(bus.rd_data), 32'h0300);
      tick();
      check("tail_gone", 32'(bus.count), 32'd0);

      // Randomized traffic, first with an eager consumer, then a sluggish one.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                       16'($urandom_range(0, 3)),
                       (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0));
         tick();
      end

      // Run the stamp counter up to its wrap point.
      applyStimulus(1'b1, 1'b1, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
      guard = 0;
      while (m_stamp != 16'hFFFF && guard < 70000) begin
         tick();
         guard++;
      end
      check("wrap_reached", 32'(guard < 70000), 32'd1);
      applyStimulus(1'b1, 1'b0, 16'h1234, 1'b1);
      tick();
      check("wrap_ffff", 32'(bus.rd_stamp), 32'hFFFF);
      applyStimulus(1'b1, 1'b0, 16'h4321, 1'b1);
      tick();
      check("wrap_zero", 32'(bus.rd_stamp), 32'h0000);
      check("wrap_data", 32'(bus.rd_data), 32'h4321);
      applyStimulus(1'b0, 1'b0, 16'h4321, 1'b1);
      repeat (5) tick();
      check("dis_empty", 32'(bus.count), 32'd0);
      applyStimulus(1'b1, 1'b0, 16'h4321, 1'b1);
      tick();
      check("reen_valid", 32'(bus.rd_valid), 32'd1);
      check("reen_stamp", 32'(bus.rd_stamp), 32'h0001);
      tick();
      check("reen_once", 32'(bus.rd_valid), 32'd0);

      // Reset asserted between edges with three entries queued.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h7000 + 16'(i), 1'b0);
         tick();
      end
      check("pre_rst_count", 32'(bus.count), 32'd3);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
      check("mid_rst_count", 32'(bus.count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h7002, 1'b0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_output_capture.md
# cpu_output_capture

Receive-side capture for the CPU core's 16-bit `Output` bus: samples the bus every clock and records each new value with a cycle timestamp into an internal FIFO. A host or bench drains entries over a valid/ready port. It sits beside the CPU core as the consumer of everything the core writes to `Output`, replacing ad-hoc cycle counting in benches.

## Interface
- `DATA_W`, 16: width of the captured CPU output bus.
- `STAMP_W`, 16: width of the cycle timestamp counter.
- `DEPTH`, 16: FIFO entries; must be a power of 2, at least 2.

- `Clk`  in  1: clock; all state updates on the rising edge.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `Enable`  in  1: capture enable; the timestamp counter and sampling run only while high.
- `Clear`  in  1: synchronous; empties the FIFO and clears `Overflow`; the counter is unaffected.
- `Cpu_Output`  in  DATA_W: CPU output bus being observed.
- `Rd_Ready`  in  1: consumer accepts the head entry.
- `Rd_Valid`  out  1: head entry present.
- `Rd_Data`  out  DATA_W: captured value at the head.
- `Rd_Stamp`  out  STAMP_W: cycle stamp at the head.
- `Count`  out  $clog2(DEPTH)+1: current occupancy.
- `Overflow`  out  1: sticky flag, set when a capture is dropped.

## Operation
- Reset values (async, `Rst_n` low): stamp counter 0, previous-value register 0, `First` flag 1, FIFO empty, `Rd_Valid` 0, `Count` 0, `Overflow` 0, `Rd_Data`/`Rd_Stamp` 0.
- The stamp counter increments by 1 on every edge while `Enable` is 1. It wraps modulo 2^STAMP_W with no event on wrap.
- Capture condition at an edge with `Enable` = 1: `First` = 1, or `Cpu_Output` differs from the previous-value register.
  - On capture, push {stamp counter value before increment, `Cpu_Output`}.
  - On capture, the previous-value register takes `Cpu_Output` and `First` clears.
- `Enable` going low freezes the counter and sampling, and sets `First` to 1, so the first sample after re-enable is always captured.
- Pop: `Rd_Valid` && `Rd_Ready` at an edge removes the head entry.
- Full FIFO with a capture and no pop: the capture is dropped, `Overflow` is set, and the previous-value register still updates. Dropped values are not retried.
- Full FIFO with a simultaneous capture and pop: both happen, no drop, `Count` unchanged.
- Empty FIFO: `Rd_Ready` is ignored and there is no underflow.
- `Clear` at an edge: FIFO empty and `Overflow` 0.
  - `Clear` has priority over a same-edge push and pop; that capture is discarded without setting `Overflow`.
  - The previous-value register still updates.
- The FIFO is first-word fall-through: `Rd_Data` and `Rd_Stamp` are read combinationally from the head slot and are stable while `Rd_Valid` && !`Rd_Ready`.
- `Rst_n` asserted mid-operation discards all entries immediately.

## Timing
- Capture latency: a change sampled at edge k gives `Rd_Valid` high after edge k (if the FIFO was empty), with `Rd_Stamp` = counter value at edge k.
- Throughput: one push and one pop per cycle.
- `Count` reflects the edge's push and pop after that edge.
- `Overflow` rises after the edge of the first dropped capture and holds until `Clear` or reset.
- Async reset assertion clears outputs without a clock; deassertion takes effect at the next edge.

## Structure
- Package `capture_pkg`:
  - entry width `DATA_W+STAMP_W`;
  - the entry struct {stamp, data};
  - default parameter constants.
- Sub-module `sync_fifo_fwft`:
  - parameterised width and depth;
  - push/pop/clear inputs, full/empty/count outputs;
  - pointers one bit wider than the address for the full/empty test.
- Top level: stamp counter, change detect, `First` flag, overflow logic.

## Test plan
- **Reset then enable, constant input.** Release `Rst_n`, `Enable`=1, `Cpu_Output`=0x0000 constant. Expect exactly one entry {stamp 0, data 0x0000}, then no more entries for 20 cycles.
- **Changes at chosen cycles.** Drive 0x0005 at counter 3 and 0x00A0 at counter 7, with `Rd_Ready`=1. Expect entries (3, 0x0005) and (7, 0x00A0), with `Rd_Valid` pulsing one cycle each.
- **Overflow and recovery.** `DEPTH`=16, `Rd_Ready`=0, 17 distinct values on consecutive cycles. Expect `Count`=16 and `Overflow`=1, and the 17th value is absent. Pulse `Clear`: expect `Count`=0 and `Overflow`=0.
- **Full with simultaneous pop.** Full FIFO, `Rd_Ready`=1, new value on the same edge. Expect `Count` to stay 16, `Overflow` to stay 0, and the new value to be the tail entry.
- **Stamp wrap and disable.** Preload the counter near 0xFFFF. Expect a change at 0xFFFF to stamp 0xFFFF and the next change to stamp 0x0000. Deassert `Enable` for 5 cycles: the counter holds. Re-enable with the same data: expect one capture.
- **Mid-operation reset.** Pull `Rst_n` low with 3 entries queued. Expect `Rd_Valid`=0 and `Count`=0 immediately, before any clock edge.
